// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection, forwarding select and mult/div scoreboard for the 5-stage MIPS pipeline,
// with saturating stall/flush performance counters.
module hazard_scoreboard_unit #(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic             MulDivD,
    input  logic             HiLoReadD,
    input  logic             MulDivStartE,
    input  logic             CntClear,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             FlushD,
    output logic [1:0]       ForwardAD,
    output logic [1:0]       ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int MD_W = 8;

    logic [MD_W-1:0] md_cnt;
    logic            e_dst_ok, m_dst_ok, w_dst_ok, m_load_ok;
    logic            lu, br, md, stall;

    // A zero destination never matches, so register 0 can't stall or forward.
    assign e_dst_ok  = (WriteRegE != '0);
    assign m_dst_ok  = RegWriteM & (WriteRegM != '0);
    assign w_dst_ok  = RegWriteW & (WriteRegW != '0);
    assign m_load_ok = MemtoRegM & (WriteRegM != '0);

    assign lu = MemtoRegE & e_dst_ok & ((WriteRegE == RsD) | (WriteRegE == RtD));
    assign br = BranchD &
                ((RegWriteE & e_dst_ok & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                 (m_load_ok & ((WriteRegM == RsD) | (WriteRegM == RtD))));
    assign md = (MulDivBusy | MulDivStartE) & (MulDivD | HiLoReadD);

    assign stall  = lu | br | md;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign FlushD = (PCSrcD | JumpD) & ~stall;

    always_comb begin
        ForwardAD = 2'b00;
        ForwardBD = 2'b00;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (m_dst_ok && WriteRegM == RsD)      ForwardAD = 2'b01;
        else if (w_dst_ok && WriteRegW == RsD) ForwardAD = 2'b10;
        if (m_dst_ok && WriteRegM == RtD)      ForwardBD = 2'b01;
        else if (w_dst_ok && WriteRegW == RtD) ForwardBD = 2'b10;
        if (m_dst_ok && WriteRegM == RsE)      ForwardAE = 2'b10;
        else if (w_dst_ok && WriteRegW == RsE) ForwardAE = 2'b01;
        if (m_dst_ok && WriteRegM == RtE)      ForwardBE = 2'b10;
        else if (w_dst_ok && WriteRegW == RtE) ForwardBE = 2'b01;
    end

    assign MulDivBusy = (md_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (MulDivStartE) begin
            md_cnt <= MD_W'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || CntClear) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
            if (FlushD && FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed testbench for hazard_scoreboard_unit; a second instance with 2-bit counters
// shares the stimulus to exercise counter saturation.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, JumpD, MulDivD, HiLoReadD, MulDivStartE, CntClear;
    logic       StallF, StallD, FlushE, FlushD, MulDivBusy;
    logic [1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE;
    logic [15:0] StallCount, FlushCount;

    logic       s_StallF, s_StallD, s_FlushE, s_FlushD, s_MulDivBusy;
    logic [1:0] s_ForwardAD, s_ForwardBD, s_ForwardAE, s_ForwardBE;
    logic [1:0] s_StallCount, s_FlushCount;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_W(5), .MD_LAT(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .JumpD(JumpD), .MulDivD(MulDivD), .HiLoReadD(HiLoReadD),
        .MulDivStartE(MulDivStartE), .CntClear(CntClear),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .MulDivBusy(MulDivBusy),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_scoreboard_unit #(.REG_W(5), .MD_LAT(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .JumpD(JumpD), .MulDivD(MulDivD), .HiLoReadD(HiLoReadD),
        .MulDivStartE(MulDivStartE), .CntClear(CntClear),
        .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE), .FlushD(s_FlushD),
        .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD), .ForwardAE(s_ForwardAE),
        .ForwardBE(s_ForwardBE), .MulDivBusy(s_MulDivBusy),
        .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    task automatic idle();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; PCSrcD = 0; JumpD = 0; MulDivD = 0; HiLoReadD = 0;
        MulDivStartE = 0; CntClear = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (MulDivBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", MulDivBusy); end
        checks++;
        if (StallCount !== 16'd0 || FlushCount !== 16'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d want=0/0", StallCount, FlushCount);
        end
        checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin
            failures++; $display("FAIL reset_stall got=%b want=0000", {StallF, StallD, FlushE, FlushD});
        end
        checks++;
        if ({ForwardAD, ForwardBD, ForwardAE, ForwardBE} !== 8'h00) begin
            failures++; $display("FAIL reset_fwd got=%h want=00", {ForwardAD, ForwardBD, ForwardAE, ForwardBE});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd8; RsD = 5'd8; RtD = 5'd9;
        #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            failures++; $display("FAIL lu_stall got=%b want=111", {StallF, StallD, FlushE});
        end
        tick();
        idle(); RsD = 5'd8; RtD = 5'd9; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5'd8;
        #1;
        checks++;
        if (StallD !== 1'b0 || StallCount !== 16'd1) begin
            failures++; $display("FAIL lu_release got=stall %b cnt %0d want=stall 0 cnt 1", StallD, StallCount);
        end
        tick();
        idle(); RsE = 5'd8; RtE = 5'd9; RegWriteW = 1; WriteRegW = 5'd8;
        #1;
        checks++;
        if (ForwardAE !== 2'b01 || ForwardBE !== 2'b00) begin
            failures++; $display("FAIL lu_fwd_w got=%b/%b want=01/00", ForwardAE, ForwardBE);
        end
        idle(); MemtoRegE = 1; WriteRegE = 5'd0; RsD = 5'd0; RtD = 5'd0;
        #1;
        checks++;
        if (StallD !== 1'b0) begin failures++; $display("FAIL lu_r0 got=%b want=0", StallD); end
    endtask

    task automatic test_branch();
        do_reset();
        BranchD = 1; PCSrcD = 1; RsD = 5'd3; RtD = 5'd7; RegWriteE = 1; WriteRegE = 5'd3;
        #1;
        checks++;
        if (StallD !== 1'b1 || FlushD !== 1'b0) begin
            failures++; $display("FAIL br_stall got=stall %b flushd %b want=1 0", StallD, FlushD);
        end
        tick();
        RegWriteE = 0; WriteRegE = '0; RegWriteM = 1; WriteRegM = 5'd3;
        #1;
        checks++;
        if (StallD !== 1'b0 || FlushD !== 1'b1 || ForwardAD !== 2'b01 || ForwardBD !== 2'b00) begin
            failures++; $display("FAIL br_fwd got=stall %b flushd %b fad %b fbd %b want=0 1 01 00",
                                 StallD, FlushD, ForwardAD, ForwardBD);
        end
        tick();
        idle();
        #1;
        checks++;
        if (StallCount !== 16'd1 || FlushCount !== 16'd1) begin
            failures++; $display("FAIL br_counts got=%0d/%0d want=1/1", StallCount, FlushCount);
        end
        BranchD = 1; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5'd4; RtD = 5'd4; RsD = 5'd1;
        #1;
        checks++;
        if (StallD !== 1'b1) begin failures++; $display("FAIL br_load_m got=%b want=1", StallD); end
        idle(); JumpD = 1;
        #1;
        checks++;
        if (FlushD !== 1'b1 || StallD !== 1'b0) begin
            failures++; $display("FAIL jump_flush got=flushd %b stall %b want=1 0", FlushD, StallD);
        end
        idle(); BranchD = 1; RsD = 5'd6; RegWriteE = 1; WriteRegE = 5'd5;
        #1;
        checks++;
        if (StallD !== 1'b0) begin failures++; $display("FAIL br_nomatch got=%b want=0", StallD); end
        idle();
    endtask

    task automatic test_muldiv();
        do_reset();
        MulDivStartE = 1; MulDivD = 1;
        #1;
        checks++;
        if (StallD !== 1'b1 || MulDivBusy !== 1'b0) begin
            failures++; $display("FAIL md_start_same got=stall %b busy %b want=1 0", StallD, MulDivBusy);
        end
        MulDivD = 0;
        #1;
        checks++;
        if (StallD !== 1'b0) begin failures++; $display("FAIL md_start_nouse got=%b want=0", StallD); end
        tick();
        MulDivStartE = 0; HiLoReadD = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (MulDivBusy !== 1'b1 || StallD !== 1'b1) begin
                failures++; $display("FAIL md_busy_t%0d got=busy %b stall %b want=1 1", i, MulDivBusy, StallD);
            end
            tick();
        end
        #1;
        checks++;
        if (MulDivBusy !== 1'b0 || StallD !== 1'b0 || StallCount !== 16'd4) begin
            failures++; $display("FAIL md_release got=busy %b stall %b cnt %0d want=0 0 4",
                                 MulDivBusy, StallD, StallCount);
        end
        idle();
    endtask

    task automatic test_forward();
        idle();
        RegWriteM = 1; RegWriteW = 1; WriteRegM = 5'd5; WriteRegW = 5'd5;
        RsE = 5'd5; RtE = 5'd5; RsD = 5'd5; RtD = 5'd5;
        #1;
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 8'b10_10_01_01) begin
            failures++; $display("FAIL fwd_m_prio got=%b want=10100101", {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
        RegWriteM = 0;
        #1;
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 8'b01_01_10_10) begin
            failures++; $display("FAIL fwd_w_only got=%b want=01011010", {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
        RegWriteM = 1; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RsE = 5'd0; RtE = 5'd0; RsD = 5'd0; RtD = 5'd0;
        #1;
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 8'h00) begin
            failures++; $display("FAIL fwd_r0 got=%b want=00000000", {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
        WriteRegM = 5'd12; WriteRegW = 5'd13; RsE = 5'd13; RtE = 5'd12; RsD = 5'd12; RtD = 5'd14;
        #1;
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 8'b01_10_01_00) begin
            failures++; $display("FAIL fwd_mixed got=%b want=01100100", {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
        idle();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_seq [6];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        MemtoRegE = 1; WriteRegE = 5'd10; RtD = 5'd10;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (s_StallCount !== exp_seq[i]) begin
                failures++; $display("FAIL sat_seq_%0d got=%0d want=%0d", i, s_StallCount, exp_seq[i]);
            end
        end
        checks++;
        if (StallCount !== 16'd6) begin failures++; $display("FAIL sat_wide got=%0d want=6", StallCount); end
        CntClear = 1;
        tick();
        checks++;
        if (s_StallCount !== 2'd0 || StallCount !== 16'd0) begin
            failures++; $display("FAIL cnt_clear got=%0d/%0d want=0/0", s_StallCount, StallCount);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        MulDivStartE = 1; MemtoRegE = 1; WriteRegE = 5'd2; RsD = 5'd2;
        tick();
        MulDivStartE = 0;
        tick();
        checks++;
        if (MulDivBusy !== 1'b1 || StallCount !== 16'd2) begin
            failures++; $display("FAIL mid_pre got=busy %b cnt %0d want=1 2", MulDivBusy, StallCount);
        end
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++;
        if (MulDivBusy !== 1'b0 || StallCount !== 16'd0 || FlushCount !== 16'd0) begin
            failures++; $display("FAIL mid_reset got=busy %b cnt %0d/%0d want=0 0/0",
                                 MulDivBusy, StallCount, FlushCount);
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_forward();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
